// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (IDLE, REQ, DROP)
//   fetch_entry_t : default {pc, instr} queue entry at 32/32 bit widths
//   PC_STEP       : byte increment between sequential instruction words
package fetch_pkg;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {pc, instr} entries, organised as a shift
// register so the head is always entry 0 and comes straight from a flop.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push         : write i_push_data at the tail
//   i_pop          : drop the head (ignored when empty)
//   i_flush        : empty the queue; wins over push and pop
//   o_count        : number of valid entries
//   o_head         : head entry; keeps its last value once the queue empties
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  entry_t                       i_push_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output entry_t                       o_head
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             r_ent [DEPTH];
  entry_t             w_up  [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               w_pop_eff;
  logic [CNT_W-1:0]   w_base;

  assign w_pop_eff = i_pop && (r_count != '0);
  // Tail slot after this cycle's pop has been applied.
  assign w_base    = r_count - CNT_W'(w_pop_eff);

  // Neighbour feeding each slot when the queue shifts toward the head.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_up
      if (gi < DEPTH - 1) begin : g_mid
        assign w_up[gi] = r_ent[gi+1];
      end else begin : g_tail
        assign w_up[gi] = r_ent[gi];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (i_flush) begin
      // Entries are left untouched so the head output holds its last value.
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop_eff);
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (w_base == CNT_W'(i))) begin
          r_ent[i] <= i_push_data;
        end else if (w_pop_eff && (CNT_W'(i) < w_base)) begin
          r_ent[i] <= w_up[i];
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_ent[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake, buffers returned words in fetch_queue and presents the head as
// {pc, instr} to decode over valid/ready. A redirect flushes the queue and
// voids any outstanding read.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// o_perf_stall_cnt / o_perf_flush_cnt outputs.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   o_imem_req, o_imem_addr      : read request, held stable until i_imem_ack
//   i_imem_ack, i_imem_rdata     : read completion and data
//   i_redirect_valid/_pc         : jump/branch target from the datapath
//   o_if_valid/_instr/_pc        : queue head toward decode
//   i_id_ready                   : decode takes the head when valid & ready
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_if_valid,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic [ADDR_W-1:0]  o_if_pc,
  input  logic               i_id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_perf_stall_cnt,
  output logic [31:0]        o_perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW1   = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_imem_req;

  logic [CNT_W-1:0]  w_count;
  if_entry_t         w_head;
  if_entry_t         w_push_entry;
  logic              w_push;
  logic              w_pop;
  logic [CW1-1:0]    w_count_after;
  logic              w_space;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_push        = (r_state == REQ) && i_imem_ack;
  assign w_pop         = o_if_valid && i_id_ready;
  assign w_push_entry  = '{pc: r_fetch_pc, instr: i_imem_rdata};
  // Occupancy once this cycle's enqueue and dequeue have both landed; a new
  // request is only started when that leaves a free slot, so pushes never
  // find the queue full.
  assign w_count_after = {1'b0, w_count} + CW1'(w_push) - CW1'(w_pop);
  assign w_space       = w_count_after < CW1'(DEPTH);
  assign w_redirect_pc = i_redirect_pc & ~ADDR_W'(3);
  assign w_pc_inc      = r_fetch_pc + ADDR_W'(PC_STEP);

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (if_entry_t)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .i_push_data (w_push_entry),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      if ((r_state != IDLE) && !i_imem_ack) begin
        // The outstanding read must finish at its original address; DROP
        // keeps req/addr as they are and swallows the returning word.
        r_state <= DROP;
      end else begin
        r_state     <= REQ;
        r_imem_req  <= 1'b1;
        r_imem_addr <= w_redirect_pc;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_space) begin
            r_state     <= REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
          end
        end
        REQ: begin
          if (i_imem_ack) begin
            r_fetch_pc  <= w_pc_inc;
            r_imem_addr <= w_pc_inc;
            if (!w_space) begin
              r_state    <= IDLE;
              r_imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (i_imem_ack) begin
            r_state     <= REQ;
            r_imem_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_imem_addr;
  assign o_if_valid  = (w_count != '0);
  assign o_if_instr  = w_head.instr;
  assign o_if_pc     = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (r_imem_req && !i_imem_ack && (r_perf_stall_cnt != '1)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (i_redirect_valid && (r_perf_flush_cnt != '1)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus a randomized phase. A
// behavioural memory answers requests with a configurable latency, and a
// scoreboard predicts the accepted instruction stream as "consecutive words
// from the last redirect target (or reset PC)".
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic        i_id_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_perf_stall_cnt;
  logic [31:0] o_perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_if_valid       (o_if_valid),
    .o_if_instr       (o_if_instr),
    .o_if_pc          (o_if_pc),
    .i_id_ready       (i_id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_stall_cnt (o_perf_stall_cnt),
    .o_perf_flush_cnt (o_perf_flush_cnt)
`endif
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_acc = 0;
  int          wait_cnt = 0;
  int          cur_lat = 0;
  int          lat_fixed = 0;
  bit          lat_rand = 1'b0;
  logic [31:0] exp_pc = '0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  int          stall_m = 0;
  int          flush_m = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic tick();
    if (prev_req && !prev_ack) begin
      chk("req_held", 32'(o_imem_req), 32'd1);
      chk("addr_held", o_imem_addr, prev_addr);
    end
    if (o_imem_req && (wait_cnt >= cur_lat)) begin
      i_imem_ack   = 1'b1;
      i_imem_rdata = mem_fn(o_imem_addr);
    end else begin
      i_imem_ack   = 1'b0;
      i_imem_rdata = $urandom;
    end
    if (i_redirect_valid) begin
      exp_pc = i_redirect_pc & ~32'h3;
      flush_m++;
    end else if (o_if_valid && i_id_ready) begin
      chk("sb_pc", o_if_pc, exp_pc);
      chk("sb_instr", o_if_instr, mem_fn(exp_pc));
      $display("accept pc=0x%08h instr=0x%08h", o_if_pc, o_if_instr);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (o_imem_req && !i_imem_ack) stall_m++;
    prev_req  = o_imem_req;
    prev_ack  = i_imem_ack;
    prev_addr = o_imem_addr;
    @(posedge clk);
    if (prev_req) begin
      if (prev_ack) begin
        wait_cnt = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end else begin
        wait_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst            = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_imem_ack       = 1'b0;
    i_imem_rdata     = '0;
    i_id_ready       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, 32'd0);
    chk("rst_valid", 32'(o_if_valid), 32'd0);
    chk("rst_instr", o_if_instr, 32'd0);
    chk("rst_pc", o_if_pc, 32'd0);
    i_rst    = 1'b0;
    exp_pc   = '0;
    wait_cnt = 0;
    cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    stall_m  = 0;
    flush_m  = 0;
  endtask

  initial begin
    // T1: zero-wait stream from reset
    lat_fixed = 0;
    do_reset();
    chk("t1_s0_req", 32'(o_imem_req), 32'd0);
    tick();
    chk("t1_s1_req", 32'(o_imem_req), 32'd1);
    chk("t1_s1_valid", 32'(o_if_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 32'(o_if_valid), 32'd1);
      chk("t1_pc", o_if_pc, 32'(k * 4));
      tick();
    end

    // T2: decode stalled five cycles, queue fills to two then request stops
    do_reset();
    i_id_ready = 1'b0;
    repeat (4) tick();
    chk("t2_req_low", 32'(o_imem_req), 32'd0);
    chk("t2_valid", 32'(o_if_valid), 32'd1);
    chk("t2_pc_held", o_if_pc, 32'd0);
    tick();
    i_id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t2_stream_pc", o_if_pc, 32'(k * 4));
      tick();
    end

    // T3: latency 3, redirect in the second wait cycle
    lat_fixed = 3;
    do_reset();
    tick();
    tick();
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h40;
    tick();
    i_redirect_valid = 1'b0;
    chk("t3_stale_addr", o_imem_addr, 32'd0);
    tick();
    tick();
    chk("t3_new_addr", o_imem_addr, 32'h40);
    for (int i = 0; i < 20 && !o_if_valid; i++) tick();
    chk("t3_valid", 32'(o_if_valid), 32'd1);
    chk("t3_pc", o_if_pc, 32'h40);
    tick();

    // T4: redirect to unaligned 0x103 in the cycle 0x8 is acked
    lat_fixed = 0;
    do_reset();
    i_id_ready = 1'b0;
    repeat (3) tick();
    chk("t4_full_req", 32'(o_imem_req), 32'd0);
    i_id_ready = 1'b1;
    tick();
    chk("t4_addr8", o_imem_addr, 32'h8);
    chk("t4_head4", o_if_pc, 32'h4);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h103;
    tick();
    i_redirect_valid = 1'b0;
    chk("t4_flushed", 32'(o_if_valid), 32'd0);
    chk("t4_addr", o_imem_addr, 32'h100);
    for (int i = 0; i < 10 && !o_if_valid; i++) tick();
    chk("t4_pc", o_if_pc, 32'h100);
    tick();

    // T5: PC wraps past the top of the address space
    do_reset();
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFE;
    tick();
    i_redirect_valid = 1'b0;
    chk("t5_addr_top", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_wrap", o_imem_addr, 32'h0);
    chk("t5_head", o_if_pc, 32'hFFFF_FFFC);
    tick();
    tick();

    // T6: reset while a slow request is outstanding (checked inside do_reset)
    lat_fixed = 3;
    do_reset();
    tick();
    tick();
    do_reset();

    // T7: randomized traffic
    lat_rand = 1'b1;
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 800; c++) begin
      i_id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        i_redirect_valid = 1'b1;
        i_redirect_pc    = $urandom;
      end else begin
        i_redirect_valid = 1'b0;
      end
      tick();
    end
    i_redirect_valid = 1'b0;
    chk("t7_progress", 32'(n_acc >= 40), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", o_perf_stall_cnt, 32'(stall_m));
    chk("perf_flush", o_perf_flush_cnt, 32'(flush_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
